// File: rtl/bus_arbiter_pkg.sv
// Shared types and sizing helpers for the peripheral bus arbiter.
// Holds the FSM state encoding, default parameter values and the
// counter-width derivations used by the arbiter and its interface.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int N_MASTERS_DEF = 4;
  localparam int MAX_BURST_DEF = 4;
  localparam int TIMEOUT_DEF   = 255;

  // Bits needed to hold v distinct values (0..v-1), never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // burst_cnt saturates at max_burst, so it must hold 0..max_burst.
  function automatic int burst_cnt_w(input int max_burst);
    return clog2(max_burst + 1);
  endfunction

  // wait_cnt stops at timeout-1, so it must hold 0..timeout-1.
  function automatic int wait_cnt_w(input int timeout);
    return clog2(timeout);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant and bus-strobe bundle between the masters and the arbiter.
// master: the requesting side; slave: the arbiter watching the bus.
// fc_bus is a shared open line and travels as a separate inout port.
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = N_MASTERS_DEF
);
  localparam int OW = clog2(N_MASTERS);

  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] grant;
  logic [OW-1:0]        owner;
  logic                 busy;
  logic                 rd_bus;
  logic                 wr_bus;
  logic                 bus_err;

  modport master (
    output req, rd_bus, wr_bus,
    input  grant, owner, busy, bus_err
  );

  modport slave (
    input  req, rd_bus, wr_bus,
    output grant, owner, busy, bus_err
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin selector: first requesting index at or after ptr, wrapping.
// Latency: purely combinational; the arbiter registers the result.
// Backpressure: none; vld=0 when no request bit is set.
module rr_picker
  import bus_arbiter_pkg::*;
#(
  parameter int N  = N_MASTERS_DEF,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          vld,
  output logic [IW-1:0] idx
);

  localparam logic [IW:0] NV = (IW + 1)'(N);

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    vld  = 1'b0;
    idx  = '0;
    sum  = '0;
    cand = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IW + 1)'(i);
      if (sum >= NV) sum = sum - NV;
      cand = sum[IW-1:0];
      if (req[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbitration for the peripheral bus, with burst pre-emption and fc timeout.
// Latency: grant is registered, one edge after req; at least one grant=0 cycle on handover.
// Backpressure: grant is frozen while a transfer is in flight; a missing fc is forced after TIMEOUT.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = N_MASTERS_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  bus_arbiter_if.slave   bus,
  inout  wire            fc_bus
);

  localparam int OW = clog2(N_MASTERS);
  localparam int BW = burst_cnt_w(MAX_BURST);
  localparam int WW = wait_cnt_w(TIMEOUT);

  localparam logic [OW-1:0] LAST_IDX  = OW'(N_MASTERS - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(TIMEOUT - 1);

  arb_state_t           state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        ptr_q, ptr_d;
  logic [BW-1:0]        burst_q, burst_d;
  logic [WW-1:0]        wait_q;
  logic                 to_flag_q;

  logic                 inflight;
  logic                 completion;
  logic                 pick_vld;
  logic [OW-1:0]        pick_idx;
  logic                 owner_req;
  logic                 others_req;

  // A floating fc line is not a completion; only a driven 1 counts.
  assign inflight   = bus.rd_bus | bus.wr_bus;
  assign completion = inflight & (fc_bus === 1'b1);
  assign owner_req  = bus.req[owner_q];
  assign others_req = |(bus.req & ~grant_q);

  // The arbiter only ever drives fc high, and only during the timeout pulse.
  assign fc_bus       = to_flag_q ? 1'b1 : 1'bz;
  assign bus.bus_err  = to_flag_q;
  assign bus.grant    = grant_q;
  assign bus.owner    = owner_q;
  assign bus.busy     = |grant_q;

  rr_picker #(
    .N  (N_MASTERS),
    .IW (OW)
  ) u_rr_picker (
    .req (bus.req),
    .ptr (ptr_q),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  // State and ownership registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
    end
  end

  // Next-state: grant on request, release when idle-on-bus and owner is done or pre-empted.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;

    if (completion && (burst_q != BURST_MAX)) burst_d = burst_q + BW'(1);

    case (state_q)
      IDLE, RELEASE: begin
        if (pick_vld) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          ptr_d             = (pick_idx == LAST_IDX) ? '0 : pick_idx + OW'(1);
          burst_d           = '0;
          state_d           = OWNED;
        end else begin
          state_d = IDLE;
        end
      end
      OWNED: begin
        // Never pull the bus from under a transfer in flight.
        if (!inflight && (!owner_req || ((burst_q == BURST_MAX) && others_req))) begin
          grant_d = '0;
          state_d = RELEASE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Count in-flight cycles with no answer; fire one terminating pulse at TIMEOUT-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q    <= '0;
      to_flag_q <= 1'b0;
    end else begin
      if (!inflight || completion) begin
        wait_q <= '0;
      end else if (wait_q != WAIT_MAX) begin
        wait_q <= wait_q + WW'(1);
      end
      to_flag_q <= inflight && !completion && (wait_q == WAIT_MAX);
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: 4 masters, MAX_BURST=4, TIMEOUT=8.
// Each scenario task drives the bus and checks against hand-computed values.
module tb_bus_arbiter;

  logic clk;
  logic rst;
  logic dev_fc;
  wire  fc_bus;
  int   n_cmp = 0;
  int   n_err = 0;

  bus_arbiter_if #(.N_MASTERS(4)) bif ();

  assign fc_bus = dev_fc ? 1'b1 : 1'bz;

  bus_arbiter #(
    .N_MASTERS (4),
    .MAX_BURST (4),
    .TIMEOUT   (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bif.slave),
    .fc_bus (fc_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One read answered by the device on its second in-flight cycle.
  task automatic do_xfer;
    bif.rd_bus = 1'b1;
    tick();
    dev_fc = 1'b1;
    tick();
    bif.rd_bus = 1'b0;
    dev_fc = 1'b0;
  endtask

  task automatic go_idle;
    bif.req = 4'b0000;
    bif.rd_bus = 1'b0;
    bif.wr_bus = 1'b0;
    dev_fc = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bif.req = 4'b0000;
    bif.rd_bus = 1'b0;
    bif.wr_bus = 1'b0;
    dev_fc = 1'b0;
    #2 rst = 1'b0;
    tick();
    tick();
    n_cmp++; if (bif.grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b want 0000", bif.grant); end
    n_cmp++; if (bif.owner !== 2'd0) begin n_err++; $display("FAIL reset_owner: got %0d want 0", bif.owner); end
    n_cmp++; if (bif.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bif.busy); end
    n_cmp++; if (bif.bus_err !== 1'b0) begin n_err++; $display("FAIL reset_bus_err: got %b want 0", bif.bus_err); end
    n_cmp++; if (fc_bus === 1'b1) begin n_err++; $display("FAIL reset_fc: got %b want z", fc_bus); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_handover;
    bif.req = 4'b0110;
    tick();
    n_cmp++; if (bif.grant !== 4'b0010) begin n_err++; $display("FAIL ho_first_grant: got %b want 0010", bif.grant); end
    n_cmp++; if (bif.owner !== 2'd1) begin n_err++; $display("FAIL ho_first_owner: got %0d want 1", bif.owner); end
    n_cmp++; if (bif.busy !== 1'b1) begin n_err++; $display("FAIL ho_busy: got %b want 1", bif.busy); end
    bif.req = 4'b0100;
    tick();
    n_cmp++; if (bif.grant !== 4'b0000) begin n_err++; $display("FAIL ho_gap: got %b want 0000", bif.grant); end
    n_cmp++; if (bif.busy !== 1'b0) begin n_err++; $display("FAIL ho_gap_busy: got %b want 0", bif.busy); end
    tick();
    n_cmp++; if (bif.grant !== 4'b0100) begin n_err++; $display("FAIL ho_second_grant: got %b want 0100", bif.grant); end
    n_cmp++; if (bif.owner !== 2'd2) begin n_err++; $display("FAIL ho_second_owner: got %0d want 2", bif.owner); end
    go_idle();
  endtask

  task automatic test_preempt;
    bif.req = 4'b0001;
    tick();
    n_cmp++; if (bif.grant !== 4'b0001) begin n_err++; $display("FAIL pre_grant0: got %b want 0001", bif.grant); end
    bif.req = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      do_xfer();
      n_cmp++; if (bif.grant !== 4'b0001) begin n_err++; $display("FAIL pre_hold_xfer%0d: got %b want 0001", i, bif.grant); end
      if (i == 1) begin
        tick();
        n_cmp++; if (bif.grant !== 4'b0001) begin n_err++; $display("FAIL pre_below_max: got %b want 0001", bif.grant); end
      end
    end
    tick();
    n_cmp++; if (bif.grant !== 4'b0000) begin n_err++; $display("FAIL pre_gap: got %b want 0000", bif.grant); end
    tick();
    n_cmp++; if (bif.grant !== 4'b1000) begin n_err++; $display("FAIL pre_grant3: got %b want 1000", bif.grant); end
    n_cmp++; if (bif.owner !== 2'd3) begin n_err++; $display("FAIL pre_owner3: got %0d want 3", bif.owner); end
    bif.req = 4'b0001;
    tick();
    n_cmp++; if (bif.grant !== 4'b0000) begin n_err++; $display("FAIL pre_gap2: got %b want 0000", bif.grant); end
    tick();
    n_cmp++; if (bif.grant !== 4'b0001) begin n_err++; $display("FAIL pre_regrant0: got %b want 0001", bif.grant); end
    go_idle();
  endtask

  task automatic test_lone_requester;
    bif.req = 4'b0001;
    tick();
    n_cmp++; if (bif.grant !== 4'b0001) begin n_err++; $display("FAIL lone_grant: got %b want 0001", bif.grant); end
    for (int i = 0; i < 5; i++) do_xfer();
    tick();
    n_cmp++; if (bif.grant !== 4'b0001) begin n_err++; $display("FAIL lone_no_preempt: got %b want 0001", bif.grant); end
    bif.req = 4'b0000;
    tick();
    n_cmp++; if (bif.grant !== 4'b0000) begin n_err++; $display("FAIL lone_gap: got %b want 0000", bif.grant); end
    bif.req = 4'b0001;
    tick();
    n_cmp++; if (bif.grant !== 4'b0001) begin n_err++; $display("FAIL lone_regrant: got %b want 0001", bif.grant); end
    go_idle();
  endtask

  task automatic test_hold_in_flight;
    bif.req = 4'b0010;
    tick();
    n_cmp++; if (bif.grant !== 4'b0010) begin n_err++; $display("FAIL hif_grant: got %b want 0010", bif.grant); end
    bif.rd_bus = 1'b1;
    tick();
    bif.req = 4'b0000;
    tick();
    n_cmp++; if (bif.grant !== 4'b0010) begin n_err++; $display("FAIL hif_hold1: got %b want 0010", bif.grant); end
    tick();
    n_cmp++; if (bif.grant !== 4'b0010) begin n_err++; $display("FAIL hif_hold2: got %b want 0010", bif.grant); end
    dev_fc = 1'b1;
    tick();
    n_cmp++; if (bif.grant !== 4'b0010) begin n_err++; $display("FAIL hif_hold_fc: got %b want 0010", bif.grant); end
    bif.rd_bus = 1'b0;
    dev_fc = 1'b0;
    tick();
    n_cmp++; if (bif.grant !== 4'b0000) begin n_err++; $display("FAIL hif_release: got %b want 0000", bif.grant); end
    go_idle();
  endtask

  task automatic test_timeout;
    int  first;
    bit  found;
    logic fc_seen;
    bif.req = 4'b0100;
    tick();
    n_cmp++; if (bif.grant !== 4'b0100) begin n_err++; $display("FAIL to_grant: got %b want 0100", bif.grant); end
    // Unmapped read: nobody answers.
    bif.rd_bus = 1'b1;
    first = 0; found = 1'b0; fc_seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (!found) begin
        tick();
        if (bif.bus_err === 1'b1) begin found = 1'b1; first = i; fc_seen = (fc_bus === 1'b1); end
      end
    end
    n_cmp++; if (first != 8) begin n_err++; $display("FAIL to_edge: bus_err after edge %0d want 8", first); end
    n_cmp++; if (fc_seen !== 1'b1) begin n_err++; $display("FAIL to_fc_pulse: fc=%b want 1", fc_seen); end
    n_cmp++; if (bif.grant !== 4'b0100) begin n_err++; $display("FAIL to_grant_hold: got %b want 0100", bif.grant); end
    tick();
    n_cmp++; if (bif.bus_err !== 1'b0) begin n_err++; $display("FAIL to_pulse_len: bus_err=%b want 0", bif.bus_err); end
    n_cmp++; if (fc_bus === 1'b1) begin n_err++; $display("FAIL to_fc_release: fc=%b want z", fc_bus); end
    bif.rd_bus = 1'b0;
    tick();
    // rd and wr together is never answered either.
    bif.rd_bus = 1'b1;
    bif.wr_bus = 1'b1;
    first = 0; found = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (!found) begin
        tick();
        if (bif.bus_err === 1'b1) begin found = 1'b1; first = i; end
      end
    end
    n_cmp++; if (first != 8) begin n_err++; $display("FAIL to_invalid_edge: bus_err after edge %0d want 8", first); end
    go_idle();
  endtask

  task automatic test_reset_async;
    bif.req = 4'b1000;
    tick();
    bif.rd_bus = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    n_cmp++; if (bif.bus_err !== 1'b1) begin n_err++; $display("FAIL ra_pre_pulse: bus_err=%b want 1", bif.bus_err); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (bif.grant !== 4'b0000) begin n_err++; $display("FAIL ra_to_grant: got %b want 0000", bif.grant); end
    n_cmp++; if (bif.bus_err !== 1'b0) begin n_err++; $display("FAIL ra_to_bus_err: got %b want 0", bif.bus_err); end
    n_cmp++; if (fc_bus === 1'b1) begin n_err++; $display("FAIL ra_to_fc: got %b want z", fc_bus); end
    n_cmp++; if (bif.owner !== 2'd0) begin n_err++; $display("FAIL ra_to_owner: got %0d want 0", bif.owner); end
    bif.rd_bus = 1'b0;
    bif.req = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b1;
    bif.req = 4'b0100;
    tick();
    n_cmp++; if (bif.grant !== 4'b0100) begin n_err++; $display("FAIL ra_tenure_grant: got %b want 0100", bif.grant); end
    bif.rd_bus = 1'b1;
    tick();
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (bif.grant !== 4'b0000) begin n_err++; $display("FAIL ra_mid_grant: got %b want 0000", bif.grant); end
    n_cmp++; if (bif.busy !== 1'b0) begin n_err++; $display("FAIL ra_mid_busy: got %b want 0", bif.busy); end
    bif.rd_bus = 1'b0;
    bif.req = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b1;
    bif.req = 4'b1111;
    tick();
    n_cmp++; if (bif.grant !== 4'b0001) begin n_err++; $display("FAIL ra_after_grant: got %b want 0001", bif.grant); end
  endtask

  // Continues from test_reset_async: master 0 owns, all four requesting.
  task automatic test_round_robin;
    int exp_order [4] = '{1, 2, 3, 0};
    int cur;
    logic [3:0] exp_grant;
    cur = 0;
    for (int k = 0; k < 4; k++) begin
      do_xfer();
      bif.req[cur] = 1'b0;
      tick();
      n_cmp++; if (bif.grant !== 4'b0000) begin n_err++; $display("FAIL rr_gap%0d: got %b want 0000", k, bif.grant); end
      bif.req[cur] = 1'b1;
      tick();
      exp_grant = 4'b0000;
      exp_grant[exp_order[k]] = 1'b1;
      n_cmp++; if (bif.grant !== exp_grant) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", k, bif.grant, exp_grant); end
      n_cmp++; if (bif.owner !== 2'(exp_order[k])) begin n_err++; $display("FAIL rr_owner%0d: got %0d want %0d", k, bif.owner, exp_order[k]); end
      cur = exp_order[k];
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_handover();
    test_preempt();
    test_lone_requester();
    test_hold_in_flight();
    test_timeout();
    test_reset_async();
    test_round_robin();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
